// File: rtl/exm_muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package exm_muldiv_pkg;

   // funct3 encoding: bit 2 selects divide, bit 1 remainder, bit 0 unsigned (for divides)
   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PREP = 2'd1,
      ST_BUSY = 2'd2,
      ST_DONE = 2'd3
   } md_state_t;

endpackage

// File: rtl/exm_muldiv_step.sv
// One bit of work on the {hi, lo} accumulator: a shift-add multiply step
// or a restoring-divide step, chosen by is_div.
module exm_muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic            is_div,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   input  logic [XLEN-1:0] operand,
   output logic [XLEN-1:0] hi_next,
   output logic [XLEN-1:0] lo_next
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
      shifted = {hi, lo[XLEN-1]};
      diff    = shifted - {1'b0, operand};
      if (is_div) begin
         // partial remainder stays below the divisor, so diff's top bit is a borrow flag
         if (!diff[XLEN]) begin
            hi_next = diff[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], 1'b1};
         end else begin
            hi_next = shifted[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_next = sum[XLEN:1];
         lo_next = {sum[0], lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/exm_muldiv.sv
// Iterative RV32M multiply/divide unit: magnitudes are processed STEP bits
// per cycle, then sign-corrected; handles divide-by-zero and overflow in one cycle.
module exm_muldiv
   import exm_muldiv_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int STEP = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   output logic            input_ready_o,
   input  logic            input_valid_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] operand1_i,
   input  logic [XLEN-1:0] operand2_i,
   input  logic [4:0]      reg_addr_i,
   input  logic            flush_i,
   input  logic            output_ready_i,
   output logic            output_valid_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      reg_addr_o,
   output logic            busy_o,
   output md_state_t       state_o
);

   localparam int K  = XLEN / STEP;
   localparam int CW = $clog2(K + 1);

   md_state_t       state;
   md_op_t          op_q;
   logic [XLEN-1:0] op1_q, op2_q, divisor_q, hi_q, lo_q;
   logic [CW-1:0]   count_q;
   logic            neg_q;

   logic            signed1, signed2, sign1, sign2, div_zero, div_ovf;
   logic [XLEN-1:0] abs1, abs2;

   always_comb begin
      signed1  = op_q inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
      signed2  = op_q inside {MD_MULH, MD_DIV, MD_REM};
      sign1    = signed1 & op1_q[XLEN-1];
      sign2    = signed2 & op2_q[XLEN-1];
      abs1     = sign1 ? -op1_q : op1_q;
      abs2     = sign2 ? -op2_q : op2_q;
      div_zero = (op2_q == '0);
      div_ovf  = (op1_q == {1'b1, {(XLEN-1){1'b0}}}) && (&op2_q);
   end

   logic [XLEN-1:0] hi_c [0:STEP];
   logic [XLEN-1:0] lo_c [0:STEP];

   assign hi_c[0] = hi_q;
   assign lo_c[0] = lo_q;

   for (genvar g = 0; g < STEP; g++) begin : g_step
      exm_muldiv_step #(.XLEN(XLEN)) u_step (
         .is_div  (op_q[2]),
         .hi      (hi_c[g]),
         .lo      (lo_c[g]),
         .operand (divisor_q),
         .hi_next (hi_c[g+1]),
         .lo_next (lo_c[g+1])
      );
   end

   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, final_res;

   always_comb begin
      prod   = {hi_c[STEP], lo_c[STEP]};
      // high-half results need the full-width negate so the borrow reaches the top word
      prod_s = neg_q ? -prod : prod;
      quo_s  = neg_q ? -lo_c[STEP] : lo_c[STEP];
      rem_s  = neg_q ? -hi_c[STEP] : hi_c[STEP];
      case (op_q)
         MD_MUL:                       final_res = prod[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              final_res = quo_s;
         default:                      final_res = rem_s;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= ST_IDLE;
         output_valid_o <= 1'b0;
         result_o       <= '0;
         reg_addr_o     <= '0;
         op_q           <= MD_MUL;
         op1_q          <= '0;
         op2_q          <= '0;
         divisor_q      <= '0;
         hi_q           <= '0;
         lo_q           <= '0;
         count_q        <= '0;
         neg_q          <= 1'b0;
      end else if (flush_i) begin
         state          <= ST_IDLE;
         output_valid_o <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (input_valid_i) begin
               op_q       <= md_op_t'(op_i);
               op1_q      <= operand1_i;
               op2_q      <= operand2_i;
               reg_addr_o <= reg_addr_i;
               state      <= ST_PREP;
            end
            ST_PREP: begin
               if (op_q[2] && div_zero) begin
                  result_o       <= op_q[1] ? op1_q : '1;
                  output_valid_o <= 1'b1;
                  state          <= ST_DONE;
               end else if (op_q[2] && !op_q[0] && div_ovf) begin
                  result_o       <= op_q[1] ? '0 : op1_q;
                  output_valid_o <= 1'b1;
                  state          <= ST_DONE;
               end else begin
                  hi_q      <= '0;
                  lo_q      <= abs1;
                  divisor_q <= abs2;
                  count_q   <= CW'(K);
                  // remainder follows the dividend's sign, everything else the product of signs
                  neg_q     <= (op_q[2] && op_q[1]) ? sign1 : (sign1 ^ sign2);
                  state     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (count_q == CW'(1)) begin
                  result_o       <= final_res;
                  output_valid_o <= 1'b1;
                  state          <= ST_DONE;
               end else begin
                  hi_q    <= hi_c[STEP];
                  lo_q    <= lo_c[STEP];
                  count_q <= count_q - CW'(1);
               end
            end
            ST_DONE: if (output_ready_i) begin
               output_valid_o <= 1'b0;
               state          <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign input_ready_o = (state == ST_IDLE);
   assign busy_o        = (state != ST_IDLE);
   assign state_o       = state;

endmodule
